// File: rtl/tel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tel_pkg
// Description : Shared definitions for the two-party phone session controller.
//               Holds the 3-bit state encoding, the ASCII constants, the six
//               8-character status strings and the character classifier.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tel_pkg;

    // Session states, 3-bit encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_RINGING  = 3'd1;
    localparam state_t c_ST_REJECTED = 3'd2;
    localparam state_t c_ST_CALLER   = 3'd3;
    localparam state_t c_ST_CALLEE   = 3'd4;
    localparam state_t c_ST_COST     = 3'd5;

    // ASCII codes with special meaning
    localparam logic [7:0] c_SPACE = 8'd32;
    localparam logic [7:0] c_BS    = 8'd8;
    localparam logic [7:0] c_DEL   = 8'd127;
    localparam logic [7:0] c_ZERO  = 8'd48;
    localparam logic [7:0] c_NINE  = 8'd57;

    // Status strings, space padded to 8 characters
    localparam logic [63:0] c_STR_IDLE     = "IDLE    ";
    localparam logic [63:0] c_STR_RINGING  = "RINGING ";
    localparam logic [63:0] c_STR_REJECTED = "REJECTED";
    localparam logic [63:0] c_STR_CALLER   = "CALLER  ";
    localparam logic [63:0] c_STR_CALLEE   = "CALLEE  ";
    localparam logic [63:0] c_STR_COST     = "COST    ";

    // Character classes
    typedef logic [2:0] charClass_t;
    localparam charClass_t c_CH_IGNORE = 3'd0;
    localparam charClass_t c_CH_PRINT  = 3'd1;  // printable, not a digit
    localparam charClass_t c_CH_DIGIT  = 3'd2;
    localparam charClass_t c_CH_BS     = 3'd3;
    localparam charClass_t c_CH_DEL    = 3'd4;

    function automatic charClass_t classifyChar(input logic [7:0] ch);
        charClass_t cls;
        if (ch == c_BS)
            cls = c_CH_BS;
        else if (ch == c_DEL)
            cls = c_CH_DEL;
        else if ((ch >= c_ZERO) && (ch <= c_NINE))
            cls = c_CH_DIGIT;
        else if ((ch >= c_SPACE) && (ch < c_DEL))
            cls = c_CH_PRINT;
        else
            cls = c_CH_IGNORE;
        return cls;
    endfunction

    function automatic logic [63:0] statusString(input state_t st);
        logic [63:0] str;
        case (st)
            c_ST_RINGING:  str = c_STR_RINGING;
            c_ST_REJECTED: str = c_STR_REJECTED;
            c_ST_CALLER:   str = c_STR_CALLER;
            c_ST_CALLEE:   str = c_STR_CALLEE;
            c_ST_COST:     str = c_STR_COST;
            default:       str = c_STR_IDLE;
        endcase
        return str;
    endfunction

endpackage : tel_pkg
`default_nettype wire

// File: rtl/tel_cost_to_ascii.sv
`default_nettype none
// ============================================================================
// Module      : tel_cost_to_ascii
// Description : Combinational binary to uppercase hex ASCII converter.
//               Nibble i of i_value becomes byte i of o_ascii, so the most
//               significant nibble lands in the most significant byte.
// Ports       : i_value [4*MSG_CHARS-1:0]  value to display
//               o_ascii [8*MSG_CHARS-1:0]  hex ASCII string
// Revision    : 1.0 - initial release
// ============================================================================
module tel_cost_to_ascii #(
    parameter int MSG_CHARS = 8
) (
    input  logic [4*MSG_CHARS-1:0] i_value,
    output logic [8*MSG_CHARS-1:0] o_ascii
);

    for (genvar i = 0; i < MSG_CHARS; i++) begin : g_digit
        logic [3:0] w_nib;
        assign w_nib = i_value[4*i +: 4];
        // '0'..'9' = 48+n, 'A'..'F' = 55+n
        assign o_ascii[8*i +: 8] = (w_nib < 4'd10) ? (8'd48 + {4'd0, w_nib})
                                                   : (8'd55 + {4'd0, w_nib});
    end

endmodule : tel_cost_to_ascii
`default_nettype wire

// File: rtl/tel_param_session.sv
`default_nettype none
// ============================================================================
// Module      : tel_param_session
// Description : Two-party phone session controller: call setup (ring, answer,
//               reject), turn-based character exchange with backspace/delete
//               editing, saturating per-character cost and a hex cost readout
//               at call end. All outputs are registered alongside the state.
// Ports       : clk, rst (async, active-high)
//               start_call, answer_call, end_call_caller, end_call_callee
//               char_sent[7:0], send_char_caller, send_char_callee
//               status_msg[63:0]          current state name
//               sent_msg[8*MSG_CHARS-1:0] message buffer or cost readout
//               total_cost[COST_W-1:0]    live cost accumulator
//               call_active               high in CALLER or CALLEE
// Revision    : 1.0 - initial release
// ============================================================================
module tel_param_session
    import tel_pkg::*;
#(
    parameter int MSG_CHARS    = 8,
    parameter int RING_TIMEOUT = 10,
    parameter int REJECT_HOLD  = 10,
    parameter int COST_HOLD    = 5,
    parameter int COST_W       = 32,
    parameter int DIGIT_COST   = 1,
    parameter int OTHER_COST   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_call,
    input  logic                   answer_call,
    input  logic                   end_call_caller,
    input  logic                   end_call_callee,
    input  logic [7:0]             char_sent,
    input  logic                   send_char_caller,
    input  logic                   send_char_callee,
    output logic [63:0]            status_msg,
    output logic [8*MSG_CHARS-1:0] sent_msg,
    output logic [COST_W-1:0]      total_cost,
    output logic                   call_active
);

    localparam int c_MSG_W    = 8*MSG_CHARS;
    localparam int c_HEX_W    = 4*MSG_CHARS;
    localparam int c_HOLD_MAX = (RING_TIMEOUT > REJECT_HOLD)
                              ? ((RING_TIMEOUT > COST_HOLD) ? RING_TIMEOUT : COST_HOLD)
                              : ((REJECT_HOLD > COST_HOLD) ? REJECT_HOLD : COST_HOLD);
    localparam int c_CNT_W    = (c_HOLD_MAX < 2) ? 1 : $clog2(c_HOLD_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RING_LAST   = c_CNT_W'(RING_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_REJECT_LAST = c_CNT_W'(REJECT_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_COST_LAST   = c_CNT_W'(COST_HOLD - 1);
    localparam logic [c_MSG_W-1:0] c_ALL_SPACES  = {MSG_CHARS{c_SPACE}};

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_holdCnt;
    logic [COST_W-1:0]    r_cost;
    logic [c_MSG_W-1:0]   r_sentMsg;
    logic [63:0]          r_status;
    logic                 r_active;

    state_t               w_nextState;
    logic [c_CNT_W-1:0]   w_nextHold;
    logic [COST_W-1:0]    w_nextCost;
    logic [c_MSG_W-1:0]   w_buf;
    logic [c_MSG_W-1:0]   w_nextMsg;
    logic [COST_W:0]      w_sum;
    logic [COST_W:0]      w_inc;
    logic                 w_strobe;
    charClass_t           w_cls;
    logic [c_HEX_W-1:0]   w_costWide;
    logic [c_MSG_W-1:0]   w_costHex;

    assign w_cls    = classifyChar(char_sent);
    assign w_strobe = ((r_state == c_ST_CALLER) && send_char_caller) ||
                      ((r_state == c_ST_CALLEE) && send_char_callee);
    // Extra carry bit detects overflow for saturation
    assign w_sum    = {1'b0, r_cost} + w_inc;

    // ------------------------------------------------------------------
    // Next-state, buffer edit and cost update
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_nextHold  = '0;
        w_nextCost  = r_cost;
        w_buf       = r_sentMsg;
        w_inc       = '0;

        case (r_state)
            c_ST_IDLE: begin
                w_nextCost = '0;
                if (start_call)
                    w_nextState = c_ST_RINGING;
            end
            c_ST_RINGING: begin
                w_nextHold = r_holdCnt + c_CNT_W'(1);
                if (end_call_caller)
                    w_nextState = c_ST_IDLE;
                else if (end_call_callee)
                    w_nextState = c_ST_REJECTED;
                else if (answer_call)
                    w_nextState = c_ST_CALLER;
                else if (r_holdCnt == c_RING_LAST)
                    w_nextState = c_ST_IDLE;
            end
            c_ST_REJECTED: begin
                w_nextHold = r_holdCnt + c_CNT_W'(1);
                if (r_holdCnt == c_REJECT_LAST)
                    w_nextState = c_ST_IDLE;
            end
            c_ST_CALLER, c_ST_CALLEE: begin
                if (w_strobe) begin
                    case (w_cls)
                        c_CH_PRINT, c_CH_DIGIT: begin
                            w_buf = (r_sentMsg << 8) | {{(c_MSG_W-8){1'b0}}, char_sent};
                            w_inc = (w_cls == c_CH_DIGIT) ? (COST_W+1)'(DIGIT_COST)
                                                          : (COST_W+1)'(OTHER_COST);
                        end
                        c_CH_BS: begin
                            w_buf = r_sentMsg >> 8;
                            w_buf[c_MSG_W-1 -: 8] = c_SPACE;
                        end
                        c_CH_DEL: begin
                            w_buf       = c_ALL_SPACES;
                            w_inc       = (COST_W+1)'(OTHER_COST);
                            w_nextState = (r_state == c_ST_CALLER) ? c_ST_CALLEE : c_ST_CALLER;
                        end
                        default: ;
                    endcase
                end
                w_nextCost = w_sum[COST_W] ? {COST_W{1'b1}} : w_sum[COST_W-1:0];
                // Hang-up wins over a DEL turn change; the char is still taken
                if (end_call_caller || end_call_callee)
                    w_nextState = c_ST_COST;
            end
            c_ST_COST: begin
                w_nextHold = r_holdCnt + c_CNT_W'(1);
                if (r_holdCnt == c_COST_LAST)
                    w_nextState = c_ST_IDLE;
            end
            default: w_nextState = c_ST_IDLE;
        endcase

        if (w_nextState != r_state)
            w_nextHold = '0;
        // Cost reads zero from the moment IDLE is entered
        if (w_nextState == c_ST_IDLE)
            w_nextCost = '0;
    end

    always_comb begin
        w_costWide                = '0;
        w_costWide[COST_W-1:0]    = w_nextCost;
    end

    tel_cost_to_ascii #(
        .MSG_CHARS (MSG_CHARS)
    ) u_costHex (
        .i_value (w_costWide),
        .o_ascii (w_costHex)
    );

    // Buffer is shown only in the call states; COST shows the readout
    always_comb begin
        case (w_nextState)
            c_ST_CALLER, c_ST_CALLEE: w_nextMsg = w_buf;
            c_ST_COST:                w_nextMsg = w_costHex;
            default:                  w_nextMsg = c_ALL_SPACES;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_holdCnt <= '0;
            r_cost    <= '0;
            r_sentMsg <= c_ALL_SPACES;
            r_status  <= c_STR_IDLE;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_holdCnt <= w_nextHold;
            r_cost    <= w_nextCost;
            r_sentMsg <= w_nextMsg;
            r_status  <= statusString(w_nextState);
            r_active  <= (w_nextState == c_ST_CALLER) || (w_nextState == c_ST_CALLEE);
        end
    end

    assign status_msg  = r_status;
    assign sent_msg    = r_sentMsg;
    assign total_cost  = r_cost;
    assign call_active = r_active;

endmodule : tel_param_session
`default_nettype wire

// File: tb/tb_tel_param_session.sv
`default_nettype none
// ============================================================================
// Module      : tb_tel_param_session
// Description : Directed self-checking bench for tel_param_session. Instance
//               dutA uses default generics; dutB (COST_W=4) shares the same
//               stimulus and is checked for cost saturation.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tel_param_session;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_call, answer_call, end_call_caller, end_call_callee;
    logic [7:0]  char_sent;
    logic        send_char_caller, send_char_callee;

    logic [63:0] statusA, statusB;
    logic [63:0] msgA, msgB;
    logic [31:0] costA;
    logic [3:0]  costB;
    logic        actA, actB;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] c_SPACES = "        ";

    always #5 clk = ~clk;

    tel_param_session dutA (
        .clk(clk), .rst(rst),
        .start_call(start_call), .answer_call(answer_call),
        .end_call_caller(end_call_caller), .end_call_callee(end_call_callee),
        .char_sent(char_sent),
        .send_char_caller(send_char_caller), .send_char_callee(send_char_callee),
        .status_msg(statusA), .sent_msg(msgA), .total_cost(costA), .call_active(actA)
    );

    tel_param_session #(.COST_W(4)) dutB (
        .clk(clk), .rst(rst),
        .start_call(start_call), .answer_call(answer_call),
        .end_call_caller(end_call_caller), .end_call_callee(end_call_callee),
        .char_sent(char_sent),
        .send_char_caller(send_char_caller), .send_char_callee(send_char_callee),
        .status_msg(statusB), .sent_msg(msgB), .total_cost(costB), .call_active(actB)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; strobes are single-cycle
    task automatic tick();
        @(posedge clk);
        #1;
        start_call       = 1'b0;
        answer_call      = 1'b0;
        end_call_caller  = 1'b0;
        end_call_callee  = 1'b0;
        send_char_caller = 1'b0;
        send_char_callee = 1'b0;
        char_sent        = 8'd0;
    endtask

    task automatic sendCaller(input logic [7:0] ch);
        char_sent = ch; send_char_caller = 1'b1; tick();
    endtask

    task automatic sendCallee(input logic [7:0] ch);
        char_sent = ch; send_char_callee = 1'b1; tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_call = 0; answer_call = 0; end_call_caller = 0; end_call_callee = 0;
        char_sent = 0; send_char_caller = 0; send_char_callee = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_status", statusA, "IDLE    ");
        chk("rst_msg",    msgA, c_SPACES);
        chk("rst_cost",   {32'd0, costA}, 64'd0);
        chk("rst_active", {63'd0, actA}, 64'd0);

        // Meaningless input in IDLE
        answer_call = 1'b1; tick();
        chk("idle_ignore_answer", statusA, "IDLE    ");

        // 1: ring timeout, exactly 10 cycles of RINGING
        start_call = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            chk("ring_hold", statusA, "RINGING ");
            if (i < 9) tick();
        end
        chk("ring_msg", msgA, c_SPACES);
        tick();
        chk("ring_timeout", statusA, "IDLE    ");

        // 2: reject in 3rd ringing cycle, 10 cycles held
        start_call = 1'b1; tick();
        tick();
        end_call_callee = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            chk("reject_hold", statusA, "REJECTED");
            if (i < 9) tick();
        end
        chk("reject_msg", msgA, c_SPACES);
        tick();
        chk("reject_end", statusA, "IDLE    ");
        // Both hang-ups together: caller wins -> IDLE
        start_call = 1'b1; tick();
        end_call_caller = 1'b1; end_call_callee = 1'b1; tick();
        chk("both_end", statusA, "IDLE    ");

        // 3: answer and exchange
        start_call = 1'b1; tick();
        answer_call = 1'b1; tick();
        chk("answer_status", statusA, "CALLER  ");
        chk("answer_active", {63'd0, actA}, 64'd1);
        sendCaller("A"); sendCaller("1"); sendCaller("b");
        chk("msg_A1b",  msgA, "     A1b");
        chk("cost_A1b", {32'd0, costA}, 64'd5);
        sendCaller(8'd5);
        chk("ctrl_ignored_msg",  msgA, "     A1b");
        chk("ctrl_ignored_cost", {32'd0, costA}, 64'd5);
        sendCaller(8'd8);
        chk("bs_msg",  msgA, "      A1");
        chk("bs_cost", {32'd0, costA}, 64'd5);
        sendCallee("X");
        chk("wrong_party_msg", msgA, "      A1");
        chk("wrong_party_status", statusA, "CALLER  ");

        // 4: DEL passes turn, then char with hang-up
        sendCaller(8'd127);
        chk("del_msg",    msgA, c_SPACES);
        chk("del_cost",   {32'd0, costA}, 64'd7);
        chk("del_status", statusA, "CALLEE  ");
        char_sent = "9"; send_char_callee = 1'b1; end_call_caller = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            chk("cost_status", statusA, "COST    ");
            chk("cost_msg",    msgA, "00000008");
            chk("cost_frozen", {32'd0, costA}, 64'd8);
            if (i < 4) tick();
        end
        tick();
        chk("post_cost_status", statusA, "IDLE    ");
        chk("post_cost_cost",   {32'd0, costA}, 64'd0);
        chk("post_cost_msg",    msgA, c_SPACES);
        chk("post_cost_active", {63'd0, actA}, 64'd0);

        // 5: saturation on the 4-bit instance
        start_call = 1'b1; tick();
        answer_call = 1'b1; tick();
        for (int i = 0; i < 7; i++) sendCaller("A");
        chk("sat_pre", {60'd0, costB}, 64'd14);
        sendCaller("A");
        chk("sat_B",    {60'd0, costB}, 64'd15);
        chk("nosat_A",  {32'd0, costA}, 64'd16);
        chk("sat_buf",  msgA, "AAAAAAAA");
        end_call_callee = 1'b1; tick();
        chk("sat_hexB", msgB, "0000000F");
        chk("hexA_16",  msgA, "00000010");
        repeat (5) tick();
        chk("sat_idle", statusB, "IDLE    ");

        // 6: async reset mid-CALLEE
        start_call = 1'b1; tick();
        answer_call = 1'b1; tick();
        sendCaller(8'd127);
        sendCallee("Z"); sendCallee("7");
        chk("pre_rst_msg", msgA, "      Z7");
        #2 rst = 1'b1;
        #1;
        chk("arst_status", statusA, "IDLE    ");
        chk("arst_msg",    msgA, c_SPACES);
        chk("arst_cost",   {32'd0, costA}, 64'd0);
        chk("arst_active", {63'd0, actA}, 64'd0);
        #1 rst = 1'b0;
        tick();
        start_call = 1'b1; tick();
        chk("rering_status", statusA, "RINGING ");
        chk("rering_msg",    msgA, c_SPACES);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tel_param_session
`default_nettype wire

// File: doc/tel_param_session.md
Name: tel_param_session

Overview:
Parametrised next-generation two-party phone session controller. It sequences call setup (ringing, answer, reject), turn-based character exchange between caller and callee, and per-character cost accumulation. At call end it shows a hex cost readout. Message width, timeouts, tariff and cost width are generics, and the block adds backspace editing, cost saturation and a call-active flag.

Parameters:
MSG_CHARS, 8, number of 8-bit characters in sent_msg and in the cost readout
RING_TIMEOUT, 10, cycles spent in RINGING before automatic return to IDLE
REJECT_HOLD, 10, cycles spent in REJECTED
COST_HOLD, 5, cycles spent in COST
COST_W, 32, width of the cost accumulator; must satisfy COST_W <= 4*MSG_CHARS
DIGIT_COST, 1, cost of an accepted digit '0'..'9'
OTHER_COST, 2, cost of any other accepted printable character and of DEL

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
start_call  input  1  caller initiates a call
answer_call  input  1  callee answers
end_call_caller  input  1  caller hangs up
end_call_callee  input  1  callee hangs up or rejects
char_sent  input  8  ASCII character presented with a send strobe
send_char_caller  input  1  caller send strobe; honoured only in CALLER
send_char_callee  input  1  callee send strobe; honoured only in CALLEE
status_msg  output  64  8-char ASCII state name, space padded
sent_msg  output  8*MSG_CHARS  message buffer or cost readout
total_cost  output  COST_W  live cost accumulator
call_active  output  1  high in CALLER or CALLEE

Behaviour:
- Reset: state IDLE; status_msg "IDLE    "; sent_msg all 8'd32; total_cost 0; call_active 0; hold counter 0.
- All outputs are registered and updated on the same edge as the state register, so status_msg always names the current state (zero lag).
- States and status strings: IDLE "IDLE    ", RINGING "RINGING ", REJECTED "REJECTED", CALLER "CALLER  ", CALLEE "CALLEE  ", COST "COST    ".
- IDLE: start_call -> RINGING. total_cost is cleared.
- RINGING: transition priority is end_call_caller -> IDLE, then end_call_callee -> REJECTED, then answer_call -> CALLER, then timeout -> IDLE after exactly RING_TIMEOUT cycles in RINGING.
- REJECTED: holds exactly REJECT_HOLD cycles, then IDLE. sent_msg is spaces throughout.
- The hold counter is cleared on every state entry.
- CALLER/CALLEE: only the strobe of the active party is honoured; the other strobe is ignored. Character classes are:
  - 32..126: shift in; byte 0 gets the new char and each older byte moves up one slot (MSB byte is discarded). Cost is DIGIT_COST for 48..57, otherwise OTHER_COST.
  - 127 (DEL): buffer cleared to spaces, cost OTHER_COST, turn passes to the other party.
  - 8 (BS): buffer shifts down one byte, space inserted at the MSB byte, cost 0. BS on an all-space buffer leaves it unchanged.
  - Any other code (0..31 except 8, and 128..255): ignored, no cost, no state change.
- End of call: end_call_caller or end_call_callee in CALLER/CALLEE -> COST. If a valid char is strobed in the same cycle it is still accepted (buffer and cost updated) before COST is entered.
- Cost arithmetic: unsigned and saturating; on overflow total_cost sticks at all-ones.
- COST: holds exactly COST_HOLD cycles, then IDLE.
  - sent_msg shows total_cost (including any char accepted on the entry edge), zero-extended to 4*MSG_CHARS bits, as MSG_CHARS uppercase hex ASCII digits with the MS nibble in the MS byte.
  - total_cost is frozen during COST.
- Call inputs arriving in states where they have no meaning are ignored.
- rst asserted in any state forces the reset values immediately.

Decomposition:
- Package tel_pkg holds:
  - the state enum (3 bits);
  - ASCII constants SPACE=32, BS=8, DEL=127, ZERO=48, NINE=57;
  - the six 64-bit status strings;
  - a function classifying a char as printable, digit, BS, DEL or ignored.
- Sub-module tel_cost_to_ascii (parameter MSG_CHARS) is combinational: it converts 4*MSG_CHARS bits to a hex ASCII string (nibble <10 -> 48+n, else 55+n).

Test Plan:
1. Defaults; start_call for 1 cycle, then nothing -> status "RINGING " for 10 cycles, then "IDLE    "; sent_msg spaces throughout.
2. start_call; in the 3rd RINGING cycle end_call_callee -> "REJECTED" for 10 cycles, then IDLE. Same cycle with both end_call_caller and end_call_callee -> IDLE directly.
3. start_call, answer_call; caller sends 'A','1','b' -> sent_msg "     A1b", total_cost 5, call_active 1. Caller sends 8'd5 -> no change. Caller sends BS -> "      A1", cost 5. Callee strobe with 'X' -> ignored.
4. Continue from 3: caller sends DEL -> sent_msg spaces, cost 7, "CALLEE  ". Callee sends '9' together with end_call_caller -> "COST    " with sent_msg "00000008" for 5 cycles, then IDLE with cost 0.
5. COST_W=4: caller sends 'A' eight times (cost 16) -> total_cost saturates at 15. end_call_callee -> sent_msg "0000000F".
6. rst pulse mid-CALLEE with a populated buffer -> same-cycle IDLE, sent_msg spaces, total_cost 0, call_active 0. Next start_call rings normally.
